// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side bundle for the shared trace FIFO write arbiter.
// master = producers + FIFO environment, slave = the arbiter.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [ID_W+DATA_WIDTH-1:0]    fifo_wr_data;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter: NUM_REQ valid/ready producers share one FIFO write
// port; each word is tagged with the granted producer's ID.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_write_arbiter_if.slave bus,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic [31:0]         word_count
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W:0]    NUM_W    = (ID_W+1)'(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                         state_q, state_d;
  logic [ID_W-1:0]                grant_id_q, grant_id_d;
  logic [ID_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]               burst_cnt_q, burst_cnt_d;
  logic [31:0]                    word_count_q, word_count_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_arr;
  logic                           pick_vld;
  logic [ID_W-1:0]                pick_id;
  logic [ID_W:0]                  idx_w;
  logic [ID_W-1:0]                idx;
  logic                           xfer;
  logic [ID_W-1:0]                rr_next;

  assign data_arr = bus.req_data;

  // Rotating priority search starting at rr_ptr; only state and req_valid feed it,
  // so fifo_full never reaches the arbitration choice.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx_w    = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx_w >= NUM_W) idx_w = idx_w - NUM_W;
      idx = idx_w[ID_W-1:0];
      if (!pick_vld && bus.req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  assign rr_next = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    word_count_d  = word_count_q;
    bus.req_ready = '0;
    xfer          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        bus.req_ready[grant_id_q] = !bus.fifo_full;
        xfer = bus.req_valid[grant_id_q] & !bus.fifo_full;
        if (xfer) begin
          burst_cnt_d  = burst_cnt_q + 1'b1;
          word_count_d = word_count_q + 32'd1;
        end
        // Full stalls without ending the burst; only a dropped valid or the last word exits.
        if (!bus.req_valid[grant_id_q] || (xfer && burst_cnt_q == CNT_LAST)) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo_wr_en   = xfer;
  assign bus.fifo_wr_data = {grant_id_q, data_arr[grant_id_q]};
  assign grant_id         = grant_id_q;
  assign busy             = (state_q == BURST);
  assign word_count       = word_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      word_count_q <= word_count_d;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench: 4-producer arbiter plus a 3-producer instance for the
// non-power-of-two wrap.
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus4 ();
  fifo_write_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(32)) bus3 ();

  logic [1:0]  grant4, grant3;
  logic        busy4, busy3;
  logic [31:0] wc4, wc3;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
    .grant_id(grant4), .busy(busy4), .word_count(wc4)
  );

  fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .MAX_BURST(4)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
    .grant_id(grant3), .busy(busy3), .word_count(wc3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data4(input int i, input logic [31:0] v);
    bus4.req_data[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    bus4.req_valid = '0;
    bus4.fifo_full = 1'b0;
    bus3.req_valid = '0;
    bus3.fifo_full = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus4.req_valid = '0;
    bus4.req_data  = '0;
    bus4.fifo_full = 1'b0;
    bus3.req_valid = '0;
    bus3.req_data  = '0;
    bus3.fifo_full = 1'b0;
    set_data4(0, 32'hD000_0000);

    // reset values
    tick();
    #1;
    chk("rst_busy", busy4, 0);
    chk("rst_wr_en", bus4.fifo_wr_en, 0);
    chk("rst_ready", bus4.req_ready, 0);
    chk("rst_wc", wc4, 0);
    chk("rst_grant", grant4, 0);
    chk("rst_wr_data", bus4.fifo_wr_data, {2'd0, 32'hD000_0000});
    rst_n = 1'b1;
    tick();

    // single producer 1: three words A,B,C then valid drops
    bus4.req_valid = 4'b0010;
    set_data4(1, 32'hAAAA_0001);
    #1;
    chk("t1_idle_busy", busy4, 0);
    chk("t1_idle_wr_en", bus4.fifo_wr_en, 0);
    tick();
    chk("t1_grant", grant4, 1);
    chk("t1_busy", busy4, 1);
    chk("t1_ready", bus4.req_ready, 4'b0010);
    chk("t1_wdA", {bus4.fifo_wr_en, bus4.fifo_wr_data}, {1'b1, 2'd1, 32'hAAAA_0001});
    tick();
    set_data4(1, 32'hBBBB_0002);
    #1;
    chk("t1_wdB", {bus4.fifo_wr_en, bus4.fifo_wr_data}, {1'b1, 2'd1, 32'hBBBB_0002});
    tick();
    set_data4(1, 32'hCCCC_0003);
    #1;
    chk("t1_wdC", {bus4.fifo_wr_en, bus4.fifo_wr_data}, {1'b1, 2'd1, 32'hCCCC_0003});
    tick();
    bus4.req_valid = 4'b0000;
    #1;
    chk("t1_drop_wr_en", bus4.fifo_wr_en, 0);
    chk("t1_drop_busy", busy4, 1);
    tick();
    chk("t1_exit_busy", busy4, 0);
    chk("t1_rr_ptr", dut.rr_ptr_q, 2);
    chk("t1_wc", wc4, 3);

    // all four continuously valid: 0,1,2,3,0 with one dead cycle each
    do_reset();
    for (int i = 0; i < 4; i++) set_data4(i, 32'h1000 + i);
    bus4.req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      logic       eb;
      logic [1:0] eg;
      eb = (c % 5) != 0;
      eg = 2'((c / 5) % 4);
      #1;
      chk($sformatf("t2_busy_c%0d", c), {busy4, bus4.fifo_wr_en}, {eb, eb});
      if (eb) chk($sformatf("t2_wd_c%0d", c), bus4.fifo_wr_data, {eg, 32'h1000 + 32'(eg)});
      tick();
    end
    chk("t2_wc", wc4, 20);

    // fifo_full for 3 cycles after word 2
    do_reset();
    set_data4(0, 32'h5555_0000);
    bus4.req_valid = 4'b0001;
    tick();
    tick();
    tick();
    bus4.fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t3_full_c%0d", c),
          {bus4.fifo_wr_en, bus4.req_ready, busy4, grant4, dut.burst_cnt_q},
          {1'b0, 4'b0000, 1'b1, 2'd0, 3'd2});
      tick();
    end
    bus4.fifo_full = 1'b0;
    #1;
    chk("t3_w3", bus4.fifo_wr_en, 1);
    tick();
    chk("t3_w4", bus4.fifo_wr_en, 1);
    tick();
    chk("t3_exit", busy4, 0);
    chk("t3_wc", wc4, 4);

    // producer 2 drops after two words while producer 3 waits
    do_reset();
    bus4.req_valid = 4'b1100;
    tick();
    chk("t4_grant2", grant4, 2);
    tick();
    tick();
    bus4.req_valid = 4'b1000;
    #1;
    chk("t4_drop_wr_en", bus4.fifo_wr_en, 0);
    tick();
    chk("t4_dead", busy4, 0);
    chk("t4_wc", wc4, 2);
    tick();
    chk("t4_grant3", {busy4, grant4}, {1'b1, 2'd3});

    // reset pulse in the middle of producer 1's burst
    do_reset();
    bus4.req_valid = 4'b1111;
    for (int c = 0; c < 7; c++) tick();
    chk("t5_pre_grant", {busy4, grant4, bus4.fifo_wr_en}, {1'b1, 2'd1, 1'b1});
    chk("t5_pre_wc", wc4, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out", {busy4, bus4.fifo_wr_en, bus4.req_ready}, 0);
    chk("t5_rst_wc", wc4, 0);
    chk("t5_rst_grant", grant4, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_idle", busy4, 0);
    tick();
    chk("t5_grant0", {busy4, grant4}, {1'b1, 2'd0});
    chk("t5_wc0", wc4, 0);
    tick();
    chk("t5_wc1", wc4, 1);

    // three producers: 0,1,2,0,1 and rr_ptr stays in range
    do_reset();
    bus3.req_valid = 3'b111;
    for (int c = 0; c < 25; c++) begin
      logic       eb;
      logic [1:0] eg;
      eb = (c % 5) != 0;
      eg = 2'((c / 5) % 3);
      #1;
      chk($sformatf("t6_busy_c%0d", c), busy3, eb);
      if (eb) chk($sformatf("t6_grant_c%0d", c), grant3, eg);
      chk($sformatf("t6_rr_c%0d", c), (u3.rr_ptr_q == 2'd3), 0);
      tick();
    end
    chk("t6_wc", wc3, 20);
    chk("t6_rr_end", u3.rr_ptr_q, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
